// File: rtl/bsg_cgol_pkg.sv
// Shared types and helpers for the CGOL job arbiter.
package bsg_cgol_pkg;

    localparam int unsigned perf_width_lp = 16;

    typedef enum logic [1:0] {
        eIDLE   = 2'd0,
        eISSUE  = 2'd1,
        eRUN    = 2'd2,
        eBYPASS = 2'd3
    } bsg_cgol_job_arb_state_e;

    // ceil(log2(n)) that never returns 0, so a 1-wide field is always legal
    function automatic int unsigned safe_clog2(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bsg_cgol_rr_pick.sv
// Round-robin pick: first set request at or above the pointer, with wrap-around.
module bsg_cgol_rr_pick
    import bsg_cgol_pkg::*;
#(
    parameter int unsigned num_req_p = 2,
    localparam int unsigned ptr_width_lp = safe_clog2(num_req_p)
) (
    input  logic [num_req_p-1:0]    req_i,
    input  logic [ptr_width_lp-1:0] ptr_i,
    output logic [ptr_width_lp-1:0] grant_o,
    output logic                    grant_v_o
);

    // scan num_req_p slots starting at the pointer, keep the first hit
    always_comb begin
        int unsigned idx;
        grant_o   = '0;
        grant_v_o = 1'b0;
        idx       = 0;
        for (int unsigned k = 0; k < num_req_p; k++) begin
            idx = (32'(ptr_i) + k) % num_req_p;
            if (!grant_v_o && req_i[idx]) begin
                grant_o   = ptr_width_lp'(idx);
                grant_v_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bsg_cgol_job_arb.sv
// Arbitrates jobs from several requesters onto one CGOL engine.
// Zero-frame jobs are answered directly without touching the engine.
// Optional: define BSG_CGOL_JOB_ARB_PERF_EN to add per-requester
// saturating completed-job counters on perf_jobs_o.
module bsg_cgol_job_arb
    import bsg_cgol_pkg::*;
#(
    parameter int unsigned max_game_length_p = 1024,
    parameter int unsigned num_req_p         = 2,
    localparam int unsigned game_len_width_lp = safe_clog2(max_game_length_p)
) (
    input  logic                                   clk_i,
    input  logic                                   reset_i,
    input  logic [num_req_p-1:0]                   req_v_i,
    input  logic [num_req_p*game_len_width_lp-1:0] req_frames_i,
    output logic [num_req_p-1:0]                   req_ready_o,
    output logic [game_len_width_lp-1:0]           eng_frames_o,
    output logic                                   eng_v_o,
    input  logic                                   eng_ready_i,
    input  logic                                   eng_v_i,
    output logic                                   eng_yumi_o,
    output logic [num_req_p-1:0]                   resp_v_o,
    input  logic [num_req_p-1:0]                   resp_yumi_i
`ifdef BSG_CGOL_JOB_ARB_PERF_EN
    ,
    output logic [num_req_p*perf_width_lp-1:0]     perf_jobs_o
`endif
);

    localparam int unsigned ptr_width_lp = safe_clog2(num_req_p);

    bsg_cgol_job_arb_state_e          state_r;
    logic [ptr_width_lp-1:0]          ptr_r;
    logic [ptr_width_lp-1:0]          owner_r;
    logic [game_len_width_lp-1:0]     frames_r;

    logic [ptr_width_lp-1:0]          grant;
    logic                             grant_v;
    logic [game_len_width_lp-1:0]     sel_frames;
    logic [ptr_width_lp-1:0]          next_ptr;
    logic                             owner_yumi;
    logic                             done;

    bsg_cgol_rr_pick #(
        .num_req_p (num_req_p)
    ) rr_pick (
        .req_i     (req_v_i),
        .ptr_i     (ptr_r),
        .grant_o   (grant),
        .grant_v_o (grant_v)
    );

    // frame count of the granted requester and the pointer after it
    always_comb begin
        sel_frames = '0;
        for (int unsigned i = 0; i < num_req_p; i++) begin
            if (grant == ptr_width_lp'(i))
                sel_frames = req_frames_i[i*game_len_width_lp +: game_len_width_lp];
        end
        next_ptr = (grant == ptr_width_lp'(num_req_p - 1)) ? '0 : grant + ptr_width_lp'(1);
    end

    // result consumed by the owning requester ends the job
    always_comb begin
        owner_yumi = 1'b0;
        for (int unsigned i = 0; i < num_req_p; i++) begin
            if (owner_r == ptr_width_lp'(i))
                owner_yumi = resp_yumi_i[i];
        end
        done = ((state_r == eRUN) && eng_v_i && owner_yumi)
            || ((state_r == eBYPASS) && owner_yumi);
    end

    // job state machine with latched owner, frames and round-robin pointer
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r  <= eIDLE;
            ptr_r    <= '0;
            owner_r  <= '0;
            frames_r <= '0;
        end else begin
            case (state_r)
                eIDLE: begin
                    if (grant_v) begin
                        owner_r  <= grant;
                        frames_r <= sel_frames;
                        ptr_r    <= next_ptr;
                        state_r  <= (sel_frames == '0) ? eBYPASS : eISSUE;
                    end
                end
                eISSUE: begin
                    if (eng_ready_i)
                        state_r <= eRUN;
                end
                eRUN, eBYPASS: begin
                    if (done)
                        state_r <= eIDLE;
                end
                default: state_r <= eIDLE;
            endcase
        end
    end

    // handshake outputs decoded from state; all forced low while in reset
    always_comb begin
        req_ready_o  = '0;
        resp_v_o     = '0;
        eng_v_o      = !reset_i && (state_r == eISSUE);
        eng_yumi_o   = !reset_i && (state_r == eRUN) && eng_v_i && owner_yumi;
        eng_frames_o = frames_r;
        for (int unsigned i = 0; i < num_req_p; i++) begin
            req_ready_o[i] = !reset_i && (state_r == eIDLE) && grant_v
                          && (grant == ptr_width_lp'(i));
            resp_v_o[i]    = !reset_i && (owner_r == ptr_width_lp'(i))
                          && (((state_r == eRUN) && eng_v_i) || (state_r == eBYPASS));
        end
    end

`ifdef BSG_CGOL_JOB_ARB_PERF_EN
    logic [perf_width_lp-1:0] perf_cnt_r [num_req_p];

    // count completed jobs per requester, holding at all-ones
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int unsigned i = 0; i < num_req_p; i++)
                perf_cnt_r[i] <= '0;
        end else if (done) begin
            for (int unsigned i = 0; i < num_req_p; i++) begin
                if ((owner_r == ptr_width_lp'(i)) && (perf_cnt_r[i] != '1))
                    perf_cnt_r[i] <= perf_cnt_r[i] + perf_width_lp'(1);
            end
        end
    end

    // flatten counters onto the output bus
    always_comb begin
        for (int unsigned i = 0; i < num_req_p; i++)
            perf_jobs_o[i*perf_width_lp +: perf_width_lp] = perf_cnt_r[i];
    end
`endif

endmodule

// File: doc/bsg_cgol_job_arb.md
BSG_CGOL_JOB_ARB -- requirements
Module: bsg_cgol_job_arb

Interface
REQ-001 SHALL have parameter max_game_length_p, default 1024, meaning the maximum frame count per job; localparam game_len_width_lp = BSG_SAFE_CLOG2(max_game_length_p).
REQ-002 SHALL have parameter num_req_p, default 2, meaning the number of requesters sharing one engine (legal 2..4).
REQ-003 SHALL have clk_i  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have reset_i  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have req_v_i  input  num_req_p  per-requester job valid.
REQ-006 SHALL have req_frames_i  input  num_req_p*game_len_width_lp  per-requester frame count; slice i is requester i.
REQ-007 SHALL have req_ready_o  output  num_req_p  per-requester job accept.
REQ-008 SHALL have eng_frames_o  output  game_len_width_lp  frame count issued to the engine.
REQ-009 SHALL have eng_v_o  output  1  job valid to the engine.
REQ-010 SHALL have eng_ready_i  input  1  engine ready to accept a job.
REQ-011 SHALL have eng_v_i  input  1  engine result valid.
REQ-012 SHALL have eng_yumi_o  output  1  engine result consumed.
REQ-013 SHALL have resp_v_o  output  num_req_p  per-requester result valid.
REQ-014 SHALL have resp_yumi_i  input  num_req_p  per-requester result consumed.

Function
REQ-015 SHALL use a state machine with states eIDLE, eISSUE, eRUN and eBYPASS.
REQ-016 In eIDLE, SHALL assert req_ready_o only at the grant index g: the first i with req_v_i[i]=1, searching from the priority pointer upward with wrap-around.
REQ-017 A job SHALL be accepted on the edge where req_v_i[g] and req_ready_o[g] are both 1; the block latches the owner g and frames; the pointer becomes (g+1) mod num_req_p.
REQ-018 An accepted job with frames != 0 SHALL go to eISSUE; one with frames == 0 SHALL go to eBYPASS and never touch the engine.
REQ-019 In eISSUE, SHALL drive eng_v_o=1 and eng_frames_o = the latched frames; on eng_ready_i=1, go to eRUN; eng_v_o is first high one cycle after acceptance.
REQ-020 In eRUN, SHALL drive resp_v_o[owner]=eng_v_i and eng_yumi_o=eng_v_i & resp_yumi_i[owner]; when that is 1, go to eIDLE.
REQ-021 In eBYPASS, SHALL drive resp_v_o[owner]=1; on resp_yumi_i[owner], go to eIDLE.
REQ-022 resp_yumi_i on a non-owner index, and eng_v_i outside eRUN, SHALL be ignored.
REQ-023 Outside eIDLE, req_ready_o SHALL be all 0; outside eISSUE, eng_v_o SHALL be 0; resp_v_o SHALL be 0 on every non-owner index.
REQ-024 A requester dropping req_v_i before acceptance SHALL NOT be granted that cycle; the pointer SHALL NOT move without an acceptance.
REQ-025 Minimum turnaround SHALL be 3 cycles: accept, then issue, then run with same-cycle result and yumi, then back in eIDLE.

Reset
REQ-026 Asserting reset_i at any time, including mid-job, SHALL immediately force eIDLE and pointer 0, and SHALL clear the latched owner and frames to 0.
REQ-027 During reset: req_ready_o=0, eng_v_o=0, eng_frames_o=0, eng_yumi_o=0, resp_v_o=0.
REQ-028 An engine job aborted by reset SHALL NOT be reported to any requester.

Configuration
REQ-029 With BSG_CGOL_JOB_ARB_PERF_EN defined, SHALL add output perf_jobs_o (num_req_p*16), a per-requester saturating count of completed jobs.
REQ-030 perf_jobs_o SHALL increment on each result yumi (eRUN or eBYPASS), SHALL saturate at 16'hFFFF, and SHALL clear on reset.
REQ-031 Without BSG_CGOL_JOB_ARB_PERF_EN, the port and its counters SHALL be absent.

Structure
REQ-032 The state enum type bsg_cgol_job_arb_state_e SHALL reside in the shared package bsg_cgol_pkg.
REQ-033 The round-robin grant logic SHALL be the sub-module bsg_cgol_rr_pick (inputs: request vector, pointer; outputs: grant index, grant valid).

Verification
REQ-034 Reset, then req_v_i=2'b11, frames 5 and 7 -> req0 granted first with eng_frames_o=5; req1 follows with eng_frames_o=7.
REQ-035 req0 valid continuously with frames 3, req1 valid continuously -> grants alternate 0,1,0,1 over 4 jobs.
REQ-036 req1 sends frames=0 -> eng_v_o stays 0; resp_v_o[1]=1 the cycle after acceptance; after yumi, back in eIDLE.
REQ-037 eng_ready_i held 0 for 10 cycles in eISSUE -> eng_v_o and eng_frames_o stay stable; req_ready_o=0 throughout.
REQ-038 reset_i pulsed mid-eRUN -> all outputs 0 asynchronously; a later eng_v_i=1 produces no resp_v_o.
REQ-039 With PERF_EN: 3 jobs for req0, 1 for req1 -> perf_jobs_o slices equal 3 and 1.
